// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants and helpers.
// The timing generator and downstream drawing stages import this package.
package vga_pkg;

  localparam logic [10:0] H_VISIBLE = 11'd640;
  localparam logic [10:0] H_FP      = 11'd16;
  localparam logic [10:0] H_SYNC    = 11'd96;
  localparam logic [10:0] H_BP      = 11'd48;
  localparam logic [10:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [10:0] V_VISIBLE = 11'd480;
  localparam logic [10:0] V_FP      = 11'd10;
  localparam logic [10:0] V_SYNC    = 11'd2;
  localparam logic [10:0] V_BP      = 11'd33;
  localparam logic [10:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] SCREEN_W  = 11'd640;
  localparam logic [10:0] SCREEN_H  = 11'd480;

  // Inclusive sync windows, derived so they track any porch change.
  localparam logic [10:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [10:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 11'd1;
  localparam logic [10:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [10:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 11'd1;

  // The three signals that travel together through the sync delay line.
  typedef struct packed {
    logic hSync;
    logic vSync;
    logic videoActive;
  } syncBits_t;

  // Idle value: both syncs deasserted (high), no active video.
  localparam syncBits_t SYNC_IDLE = '{hSync: 1'b1, vSync: 1'b1, videoActive: 1'b0};

  // Unsigned inclusive range test on 11-bit counter values.
  function automatic logic inRange(input logic [10:0] v,
                                   input logic [10:0] lo,
                                   input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Parameterised reset-able shift register used to lag the sync/active
// signals by a fixed number of clk cycles. DEPTH of 0 is a plain wire.
module sync_delay_line #(
  parameter int               WIDTH     = 3,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut
);

  generate
    if (DEPTH == 0) begin : gPass
      logic unusedClkRst;
      assign unusedClkRst = clk ^ reset;
      assign dataOut      = dataIn;
    end else begin : gShift
      logic [WIDTH-1:0] stages [DEPTH];

      // Shift one stage per clk; every stage returns to idle on reset.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) begin
            stages[i] <= RESET_VAL;
          end
        end else begin
          stages[0] <= dataIn;
          for (int i = 1; i < DEPTH; i++) begin
            stages[i] <= stages[i-1];
          end
        end
      end

      assign dataOut = stages[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 VGA timing generator: pixel clock divider, pixel/line counters,
// sync and active-video decode, optional sync delay and frame counting.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int PIX_DIV    = 2,
  parameter int SYNC_DELAY = 1
) (
  input  logic               clk,
  input  logic               reset,
  output logic signed [10:0] pixelX,
  output logic signed [10:0] pixelY,
  output logic               pixelEn,
  output logic               videoActive,
  output logic               hSync,
  output logic               vSync,
  output logic               frameStart,
  output logic [7:0]         frameCount
);

  localparam int              DIV_W    = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

  logic [DIV_W-1:0] divCount;
  logic             tick;
  logic             xWrap;
  logic             yWrap;
  logic [10:0]      xCount;
  logic [10:0]      yCount;
  logic [10:0]      xNext;
  logic [10:0]      yNext;
  logic [7:0]       frameCnt;
  syncBits_t        rawNext;
  syncBits_t        rawReg;
  syncBits_t        delayed;

  // Next-position logic; sync/active decode uses the next position so the
  // registered copies line up exactly with the registered counters.
  always_comb begin
    tick    = (divCount == DIV_LAST);
    xWrap   = (xCount == H_TOTAL - 11'd1);
    yWrap   = (yCount == V_TOTAL - 11'd1);
    xNext   = xCount;
    yNext   = yCount;
    rawNext = SYNC_IDLE;
    if (tick) begin
      if (xWrap) begin
        xNext = '0;
        yNext = yWrap ? 11'd0 : yCount + 11'd1;
      end else begin
        xNext = xCount + 11'd1;
      end
    end
    rawNext.hSync       = ~inRange(xNext, H_SYNC_START, H_SYNC_END);
    rawNext.vSync       = ~inRange(yNext, V_SYNC_START, V_SYNC_END);
    rawNext.videoActive = (xNext < SCREEN_W) && (yNext < SCREEN_H);
  end

  // Pixel clock divider, free-running 0..PIX_DIV-1 once out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      divCount <= '0;
    end else begin
      divCount <= tick ? '0 : divCount + DIV_W'(1);
    end
  end

  // Position counters, pixel strobe and frame bookkeeping; a frame only
  // counts when the counters wrap into (0,0), never on the reset origin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xCount     <= '0;
      yCount     <= '0;
      pixelEn    <= 1'b0;
      frameStart <= 1'b0;
      frameCnt   <= '0;
    end else begin
      xCount     <= xNext;
      yCount     <= yNext;
      pixelEn    <= tick;
      frameStart <= tick & xWrap & yWrap;
      if (tick & xWrap & yWrap) begin
        frameCnt <= frameCnt + 8'd1;
      end
    end
  end

  // Registered raw sync/active bits, aligned with pixelX/pixelY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rawReg <= SYNC_IDLE;
    end else begin
      rawReg <= rawNext;
    end
  end

  sync_delay_line #(
    .WIDTH     (3),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL (SYNC_IDLE)
  ) uDelay (
    .clk     (clk),
    .reset   (reset),
    .dataIn  (rawReg),
    .dataOut (delayed)
  );

  assign pixelX      = xCount;
  assign pixelY      = yCount;
  assign frameCount  = frameCnt;
  assign hSync       = delayed.hSync;
  assign vSync       = delayed.vSync;
  assign videoActive = delayed.videoActive;

endmodule
